// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, async-read instruction memory, field split, branch next-PC select.
// Latency: instruction and fields valid in the same cycle as pc; next-PC decided at the following rising edge.
// Backpressure: stall holds pc and instr_count; HALT holds everything until reset; memory writes always land.
module instr_fetch_unit #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          Branch,
    input  logic                          Zero,
    input  logic                          stall,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    output logic [31:0]                   pc,
    output logic [31:0]                   pc_plus4,
    output logic [31:0]                   instr,
    output logic [5:0]                    opcode,
    output logic [4:0]                    rs,
    output logic [4:0]                    rt,
    output logic [4:0]                    rd,
    output logic [4:0]                    shamt,
    output logic [5:0]                    funct,
    output logic [15:0]                   imm,
    output logic                          halted,
    output logic [31:0]                   instr_count
);

    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] count_nxt;
    logic [31:0] mem [IMEM_DEPTH];
    logic        in_range;
    logic [31:0] branch_target;
    logic [31:0] next_pc;

    // Program loader: synchronous write, deliberately not touched by reset
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Asynchronous fetch; out-of-range or halted fetch yields an sll nop
    always_comb begin
        in_range = (pc[31:AW+2] == '0);
        instr    = 32'h0000_0000;
        if (in_range && (state == RUN)) begin
            instr = mem[pc[AW+1:2]];
        end
    end

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign pc_plus4 = pc + 32'd4;
    assign halted   = (state == HALT);

    assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    assign next_pc       = (Branch && Zero) ? branch_target : pc_plus4;

    // State, PC and retired-instruction counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            instr_count <= 32'd0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_count <= count_nxt;
        end
    end

    // Next-state: an out-of-range pc halts even under stall; otherwise advance unless stalled
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        count_nxt = instr_count;
        case (state)
            RUN: begin
                if (!in_range) begin
                    state_nxt = HALT;
                end else if (!stall) begin
                    pc_nxt    = next_pc;
                    count_nxt = instr_count + 32'd1;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, branches, stall, program writes, halt and async reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stall and HALT holding behaviour are exercised directly.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        Branch;
    logic        Zero;
    logic        stall;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        halted;
    logic [31:0] instr_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] prog [4];

    instr_fetch_unit #(
        .IMEM_DEPTH (64),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Branch      (Branch),
        .Zero        (Zero),
        .stall       (stall),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm         (imm),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        prog[0] = 32'h8C01_0000;
        prog[1] = 32'h0022_1820;
        prog[2] = 32'h1000_0001;
        prog[3] = 32'hAC03_0004;
        reset = 1'b0; Branch = 1'b0; Zero = 1'b0; stall = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_pc",       pc,          32'h0);
        chk("rst_pc4",      pc_plus4,    32'h4);
        chk("rst_halted",   {31'd0, halted}, 32'd0);
        chk("rst_count",    instr_count, 32'd0);

        // load program while reset held
        for (int i = 0; i < 4; i++) begin
            prog_we = 1'b1; prog_addr = 6'(i); prog_data = prog[i];
            tick();
        end
        prog_we = 1'b0;
        chk("load_instr0",  instr,       32'h8C01_0000);
        chk("load_opcode0", {26'd0, opcode}, 32'h23);
        chk("load_pc",      pc,          32'h0);

        // sequential fetch
        reset = 1'b0;
        tick();
        chk("seq_pc1",      pc,          32'h4);
        chk("seq_opcode1",  {26'd0, opcode}, 32'h00);
        chk("seq_rs",       {27'd0, rs}, 32'd1);
        chk("seq_rt",       {27'd0, rt}, 32'd2);
        chk("seq_rd",       {27'd0, rd}, 32'd3);
        chk("seq_shamt",    {27'd0, shamt}, 32'd0);
        chk("seq_funct",    {26'd0, funct}, 32'h20);
        chk("seq_imm",      {16'd0, imm}, 32'h1820);
        tick();
        chk("seq_pc2",      pc,          32'h8);
        chk("seq_opcode2",  {26'd0, opcode}, 32'h04);
        tick();
        chk("seq_pc3",      pc,          32'hC);
        chk("seq_count3",   instr_count, 32'd3);

        // taken forward branch
        reset = 1'b1;
        prog_we = 1'b1; prog_addr = 6'd2; prog_data = 32'h1000_0002;
        tick();
        prog_we = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        chk("br_pc_before", pc,          32'h8);
        chk("br_instr",     instr,       32'h1000_0002);
        Branch = 1'b1; Zero = 1'b1;
        tick();
        chk("br_taken_pc",  pc,          32'h14);
        chk("br_taken_cnt", instr_count, 32'd3);

        // branch not taken (Zero=0)
        Branch = 1'b0; Zero = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        tick();
        tick();
        Branch = 1'b1; Zero = 1'b0;
        tick();
        chk("br_nt_pc",     pc,          32'hC);
        chk("br_nt_pc4",    pc_plus4,    32'h10);
        Branch = 1'b0;

        // backward branch; write lands as pc advances onto it
        prog_we = 1'b1; prog_addr = 6'd4; prog_data = 32'h1000_FFFB;
        tick();
        prog_we = 1'b0;
        chk("bk_pc",        pc,          32'h10);
        chk("bk_instr",     instr,       32'h1000_FFFB);
        chk("bk_imm",       {16'd0, imm}, 32'hFFFB);
        Branch = 1'b1; Zero = 1'b1;
        tick();
        chk("bk_target",    pc,          32'h0);
        chk("bk_count",     instr_count, 32'd5);

        // stall holds pc and counter, ignoring Branch/Zero
        Branch = 1'b0; Zero = 1'b0;
        tick();
        chk("st_pc_pre",    pc,          32'h4);
        stall = 1'b1; Branch = 1'b1; Zero = 1'b1;
        tick(); tick(); tick();
        chk("st_pc_hold",   pc,          32'h4);
        chk("st_cnt_hold",  instr_count, 32'd6);
        stall = 1'b0; Branch = 1'b0; Zero = 1'b0;
        tick();
        chk("st_pc_rel",    pc,          32'h8);
        chk("st_cnt_rel",   instr_count, 32'd7);

        // async reset pulse without an edge, then stalled program write
        reset = 1'b1;
        #1;
        chk("ar_pc",        pc,          32'h0);
        chk("ar_count",     instr_count, 32'd0);
        reset = 1'b0;
        stall = 1'b1; prog_we = 1'b1; prog_addr = 6'd0; prog_data = 32'h2002_0005;
        tick();
        prog_we = 1'b0;
        chk("wr_instr",     instr,       32'h2002_0005);
        chk("wr_opcode",    {26'd0, opcode}, 32'h08);
        chk("wr_pc",        pc,          32'h0);
        stall = 1'b0;

        // run off the end of memory into HALT
        repeat (64) tick();
        chk("h_pc_edge",    pc,          32'h100);
        chk("h_cnt_edge",   instr_count, 32'd64);
        chk("h_not_yet",    {31'd0, halted}, 32'd0);
        chk("h_instr_oor",  instr,       32'h0);
        tick();
        chk("h_halted",     {31'd0, halted}, 32'd1);
        chk("h_pc_hold",    pc,          32'h100);
        chk("h_cnt_hold",   instr_count, 32'd64);
        Branch = 1'b1; Zero = 1'b1;
        tick();
        chk("h_pc_hold2",   pc,          32'h100);
        chk("h_instr_zero", instr,       32'h0);
        Branch = 1'b0; Zero = 1'b0;

        // async reset from HALT; memory retained
        reset = 1'b1;
        #1;
        chk("hr_pc",        pc,          32'h0);
        chk("hr_halted",    {31'd0, halted}, 32'd0);
        chk("hr_count",     instr_count, 32'd0);
        chk("hr_mem0",      instr,       32'h2002_0005);
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
